// File: rtl/channel_pkg.sv
// rtl/channel_pkg.sv - shared constants, types and pointer helpers for channel blocks
//
// Purpose: common definitions for ac_channel style FIFOs.
//   CHANNEL_WIDTH  default data word width
//   chan_flags_t   full/empty flag pair derived from a pointer pair
//   ptr_width()    bits needed for a free-running wrap pointer over DEPTH entries
//   chan_flags()   full/empty compare of two free-running pointers
// No ports.
package channel_pkg;

  localparam int CHANNEL_WIDTH = 32;

  typedef struct packed {
    logic full;
    logic empty;
  } chan_flags_t;

  // One extra bit beyond the index so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointers are passed zero-extended to 32 bits; aw is the index width.
  // Full: only the wrap bit differs. Empty: pointers identical.
  function automatic chan_flags_t chan_flags(input logic [31:0] wp,
                                             input logic [31:0] rp,
                                             input int aw);
    chan_flags_t f;
    logic [31:0] msb;
    logic [31:0] ptr_mask;
    logic [31:0] diff;
    msb      = 32'd1 << aw;
    ptr_mask = (msb << 1) - 32'd1;
    diff     = (wp ^ rp) & ptr_mask;
    f.full   = (diff == msb);
    f.empty  = (diff == 32'd0);
    return f;
  endfunction

endpackage

// File: rtl/channel_fifo_if.sv
// rtl/channel_fifo_if.sv - ac_channel handshake bundle between producer, FIFO and consumer
//
// Purpose: groups the push/pop handshake of channel_fifo.
//   in_data      word to push (master -> FIFO)
//   write_valid  push strobe (master -> FIFO)
//   write_ready  FIFO not full (FIFO -> master)
//   read_valid   pop strobe (master -> FIFO)
//   read_ready   FIFO not empty (FIFO -> master)
//   out_data     last popped word, registered (FIFO -> master)
//   count        occupancy 0..DEPTH (FIFO -> master)
// Modports: master = producer/consumer side, slave = FIFO side.
interface channel_fifo_if
  import channel_pkg::*;
#(
  parameter int WIDTH = CHANNEL_WIDTH,
  parameter int DEPTH = 4
);

  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] in_data;
  logic             write_valid;
  logic             write_ready;
  logic             read_valid;
  logic             read_ready;
  logic [WIDTH-1:0] out_data;
  logic [PW-1:0]    count;

  modport master (
    output in_data, write_valid, read_valid,
    input  write_ready, read_ready, out_data, count
  );

  modport slave (
    input  in_data, write_valid, read_valid,
    output write_ready, read_ready, out_data, count
  );

endinterface

// File: rtl/channel_fifo_mem.sv
// rtl/channel_fifo_mem.sv - FIFO storage array with registered read port
//
// Purpose: DEPTH x WIDTH array, synchronous write, combinational read
// captured into an output register when re_i is high.
//   clk      clock
//   rst      synchronous active-low reset (clears the output register only)
//   we_i     write enable
//   waddr_i  write index
//   wdata_i  write data
//   re_i     output register load enable
//   raddr_i  read index
//   rdata_o  registered read data, holds between loads
module channel_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Array contents survive reset; only the pointers make them invisible.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/channel_fifo.sv
// rtl/channel_fifo.sv - registered ac_channel FIFO between two HLS stages
//
// Purpose: DEPTH-entry FIFO with free-running wrap pointers. The popped word
// is registered and held until the next accepted pop, so a consumer may pulse
// read_valid and sample out_data on the following cycle.
//   clk        clock, all state on rising edge
//   rst        synchronous active-low reset
//   ch         channel_fifo_if.slave handshake bundle
//   overflow   sticky: a push was dropped while full   (CHANNEL_FIFO_ERR_EN only)
//   underflow  sticky: a pop was ignored while empty   (CHANNEL_FIFO_ERR_EN only)
// Optional feature macro: CHANNEL_FIFO_ERR_EN.
module channel_fifo
  import channel_pkg::*;
#(
  parameter int WIDTH = CHANNEL_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  channel_fifo_if.slave ch
`ifdef CHANNEL_FIFO_ERR_EN
  ,
  output logic          overflow,
  output logic          underflow
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW-1:0] count_q, count_d;
  chan_flags_t   flags;
  logic          push_acc;
  logic          pop_acc;

  assign flags = chan_flags(32'(wp_q), 32'(rp_q), AW);

  // Acceptance is judged on the pre-edge state only: a pop does not free a
  // slot for a same-cycle push, and a push does not feed a same-cycle pop.
  assign push_acc = ch.write_valid && !flags.full;
  assign pop_acc  = ch.read_valid && !flags.empty;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q + {{(PW-1){1'b0}}, push_acc} - {{(PW-1){1'b0}}, pop_acc};
    if (push_acc) begin
      wp_d = wp_q + 1'b1;
    end
    if (pop_acc) begin
      rp_d = rp_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Strobes in the reset cycle must not touch the array or the output word.
  channel_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (push_acc && rst),
    .waddr_i (wp_q[AW-1:0]),
    .wdata_i (ch.in_data),
    .re_i    (pop_acc && rst),
    .raddr_i (rp_q[AW-1:0]),
    .rdata_o (ch.out_data)
  );

  assign ch.write_ready = !flags.full;
  assign ch.read_ready  = !flags.empty;
  assign ch.count       = count_q;

`ifdef CHANNEL_FIFO_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  || (ch.write_valid && flags.full);
    underflow_d = underflow_q || (ch.read_valid && flags.empty);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule
